pipe_ctrl: RTL

Parametrised pipeline stall/flush controller for the CPU pipeline; next generation of the hand-wired stall/flush assignments in the top level.
- Generalises stage count and flush-source count; a per-source flush mask parameter replaces the fixed OR-terms.
- Adds registered per-stage valid shadow, drain indication, sticky flush-cause capture and a stall watchdog.
- Sits in the top level between the pipeline stages and the flush/stall producers: BPU, Memory1, Exception.

---
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with per-stage valid shadow, flush-cause capture and stall watchdog.
// Optional per-stage stall performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl #(
    parameter int STAGE_NUM     = 7,
    parameter int FLUSH_SRC_NUM = 4,
    parameter logic [STAGE_NUM*FLUSH_SRC_NUM-1:0] FLUSH_MASK = {7'h0F, 7'h1F, 7'h0F, 7'h01},
    parameter int WDOG_LIMIT    = 1024,
    localparam int SRC_W = (FLUSH_SRC_NUM > 1) ? $clog2(FLUSH_SRC_NUM) : 1,
    localparam int CNT_W = $clog2(WDOG_LIMIT + 1),
    localparam int SEL_W = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [STAGE_NUM-1:0]     stall_o_vec,
    output logic [STAGE_NUM-1:0]     stall_i_vec,
    input  logic [FLUSH_SRC_NUM-1:0] flush_req,
    output logic [STAGE_NUM-1:0]     flush_i_vec,
    input  logic                     fetch_vld,
    output logic [STAGE_NUM-1:0]     stage_vld,
    output logic                     pipe_empty,
    output logic [SRC_W-1:0]         last_flush_src,
    output logic                     flush_seen,
    input  logic                     wdog_clr,
`ifdef PIPE_PERF_CNT_EN
    input  logic [SEL_W-1:0]         perf_sel,
    input  logic                     perf_clr,
    output logic [31:0]              perf_cnt,
`endif
    output logic                     wdog_timeout
);

    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(WDOG_LIMIT);

    logic [STAGE_NUM-1:0] busy;
    logic [STAGE_NUM-1:0] stage_vld_q, stage_vld_d;
    logic [SRC_W-1:0]     last_src_q, last_src_d;
    logic                 seen_q, seen_d;
    logic [CNT_W-1:0]     wdog_cnt_q, wdog_cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 any_flush;

    always_comb begin
        logic stallAcc;
        logic flushAcc;
        stall_i_vec = '0;
        flush_i_vec = '0;
        stallAcc    = 1'b0;
        for (int k = STAGE_NUM - 1; k >= 0; k--) begin
            stall_i_vec[k] = stallAcc;
            stallAcc       = stallAcc | stall_o_vec[k];
        end
        for (int k = 0; k < STAGE_NUM; k++) begin
            flushAcc = 1'b0;
            for (int s = 0; s < FLUSH_SRC_NUM; s++) begin
                flushAcc = flushAcc | (flush_req[s] & FLUSH_MASK[s*STAGE_NUM+k]);
            end
            flush_i_vec[k] = flushAcc;
        end
    end

    assign busy      = stall_o_vec | stall_i_vec;
    assign any_flush = |flush_req;

    // Flush beats stall; an upstream stage that is itself stalling hands down a bubble.
    always_comb begin
        stage_vld_d = '0;
        if (flush_i_vec[0]) begin
            stage_vld_d[0] = 1'b0;
        end else if (busy[0]) begin
            stage_vld_d[0] = stage_vld_q[0];
        end else begin
            stage_vld_d[0] = fetch_vld;
        end
        for (int k = 1; k < STAGE_NUM; k++) begin
            if (flush_i_vec[k]) begin
                stage_vld_d[k] = 1'b0;
            end else if (busy[k]) begin
                stage_vld_d[k] = stage_vld_q[k];
            end else begin
                stage_vld_d[k] = stage_vld_q[k-1] & ~stall_o_vec[k-1];
            end
        end
    end

    always_comb begin
        last_src_d = last_src_q;
        seen_d     = seen_q;
        if (any_flush) begin
            seen_d = 1'b1;
            for (int s = 0; s < FLUSH_SRC_NUM; s++) begin
                if (flush_req[s]) begin
                    last_src_d = SRC_W'(s);
                end
            end
        end
    end

    // Timeout is raised in the same edge that brings the counter to the limit.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (!busy[0] || any_flush || wdog_clr) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WDOG_MAX) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
        if (wdog_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q | (wdog_cnt_d == WDOG_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld_q <= '0;
            last_src_q  <= '0;
            seen_q      <= 1'b0;
            wdog_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stage_vld_q <= stage_vld_d;
            last_src_q  <= last_src_d;
            seen_q      <= seen_d;
            wdog_cnt_q  <= wdog_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stage_vld      = stage_vld_q;
    assign pipe_empty     = ~|stage_vld_q;
    assign last_flush_src = last_src_q;
    assign flush_seen     = seen_q;
    assign wdog_timeout   = timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_q [STAGE_NUM];
    logic [31:0] perf_d [STAGE_NUM];

    always_comb begin
        for (int k = 0; k < STAGE_NUM; k++) begin
            perf_d[k] = perf_q[k];
            if (perf_clr) begin
                perf_d[k] = '0;
            end else if (stage_vld_q[k] && busy[k] && (perf_q[k] != 32'hFFFF_FFFF)) begin
                perf_d[k] = perf_q[k] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGE_NUM; k++) begin
                perf_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGE_NUM; k++) begin
                perf_q[k] <= perf_d[k];
            end
        end
    end

    always_comb begin
        perf_cnt = '0;
        for (int k = 0; k < STAGE_NUM; k++) begin
            if (perf_sel == SEL_W'(k)) begin
                perf_cnt = perf_q[k];
            end
        end
    end
`endif

endmodule
